// File: rtl/pio_pins_pkg.sv
// Shared definitions for the Pins-block arbiter: requester count, the
// per-requester pin configuration record and its packed width.
package pio_pins_pkg;

    // Number of state-machine requesters sharing the Pins block.
    localparam int NUM_SM = 4;

    // Width of one configuration field (base or count).
    localparam int CFG_FIELD_W = 9;

    // Width of one packed pin configuration record.
    localparam int PIN_CFG_W = 4 * CFG_FIELD_W;

    // Width of one requester's write data slice.
    localparam int DATA_W = 32;

    // Packed configuration, MSB first: {inBase, inCount, outBase, outCount}.
    typedef struct packed {
        logic [CFG_FIELD_W-1:0] in_base;
        logic [CFG_FIELD_W-1:0] in_count;
        logic [CFG_FIELD_W-1:0] out_base;
        logic [CFG_FIELD_W-1:0] out_count;
    } pin_cfg_t;

endpackage

// File: rtl/pin_arbiter_rr_picker.sv
// Round-robin picker: starting at rr_i, find the first eligible requester,
// wrapping modulo N. Purely combinational.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [IDX_W:0] cand;

    // Walk the requesters from the pointer, remembering only the first hit.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!any_o && eligible_i[cand[IDX_W-1:0]]) begin
                any_o                      = 1'b1;
                grant_idx_o                = cand[IDX_W-1:0];
                grant_o[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_arbiter.sv
// Arbitrates NUM_SM state-machine requesters onto the single shared Pins
// block. One transaction may be accepted per cycle; the accepted request
// drives the Pins outputs the following cycle and its response strobe
// fires the cycle after that.
//
// Handshake: a requester holds reqValid until it sees reqAck high in the
// same cycle; reqAck is combinational and one-hot, and reqValid & reqAck at
// a rising edge is the acceptance. There is no backpressure on responses:
// rspValid is a single-cycle one-hot strobe the requester must take.
module pin_arbiter #(
    parameter int NUM_SM = pio_pins_pkg::NUM_SM
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SM-1:0]    smEnable,
    input  logic [NUM_SM-1:0]    reqValid,
    input  logic [NUM_SM-1:0]    reqWrite,
    input  logic [32*NUM_SM-1:0] reqData,
    input  logic [36*NUM_SM-1:0] reqCfg,
    input  logic [NUM_SM-1:0]    reqSideEn,
    input  logic [NUM_SM-1:0]    reqSideVal,
    output logic [NUM_SM-1:0]    reqAck,
    output logic [NUM_SM-1:0]    rspValid,
    output logic [31:0]          rspData,
    output logic [8:0]           cfg_inBase,
    output logic [8:0]           cfg_inCount,
    output logic [8:0]           cfg_outBase,
    output logic [8:0]           cfg_outCount,
    output logic [31:0]          write_data,
    output logic                 write_enable,
    output logic                 sideSet,
    input  logic [31:0]          pinRead
);

    import pio_pins_pkg::*;

    localparam int IDX_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    // Arbitration state and picker results.
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [NUM_SM-1:0] eligible;
    logic [NUM_SM-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              accept;

    // Fields of the requester being accepted this cycle.
    pin_cfg_t          sm_cfg [NUM_SM];
    pin_cfg_t          sel_cfg;
    logic [31:0]       sel_data;
    logic              sel_write;
    logic              sel_side_en;
    logic              sel_side_val;

    // Pins-facing registers (the N+1 stage).
    pin_cfg_t          cfg_q, cfg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              side_q, side_d;
    logic              pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;

    // Response registers (the N+2 stage).
    logic [NUM_SM-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;

    assign eligible = reqValid & smEnable;

    rr_picker #(
        .N     (NUM_SM),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .eligible_i  (eligible),
        .rr_i        (rr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    // Nothing is accepted while reset is held, so reqAck stays low then.
    assign accept = pick_any & ~reset;
    assign reqAck = accept ? pick_grant : '0;

    // Unpack the flat configuration bus into per-requester records.
    always_comb begin
        for (int k = 0; k < NUM_SM; k++) begin
            sm_cfg[k] = pin_cfg_t'(reqCfg[PIN_CFG_W*k +: PIN_CFG_W]);
        end
    end

    // Select the winning requester's payload.
    always_comb begin
        sel_cfg      = sm_cfg[pick_idx];
        sel_data     = reqData[DATA_W*pick_idx +: DATA_W];
        sel_write    = reqWrite[pick_idx];
        sel_side_en  = reqSideEn[pick_idx];
        sel_side_val = reqSideVal[pick_idx];
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            if (pick_idx == IDX_W'(NUM_SM - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = pick_idx + IDX_W'(1);
            end
        end
    end

    // Pins next state: reads touch only the input window so the output
    // enables on the pins are left alone; idle cycles hold everything.
    always_comb begin
        cfg_d        = cfg_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        side_d       = side_q;
        pend_valid_d = accept;
        pend_idx_d   = pend_idx_q;
        if (accept) begin
            pend_idx_d     = pick_idx;
            cfg_d.in_base  = sel_cfg.in_base;
            cfg_d.in_count = sel_cfg.in_count;
            if (sel_write) begin
                we_d            = 1'b1;
                wdata_d         = sel_data;
                cfg_d.out_base  = sel_cfg.out_base;
                cfg_d.out_count = sel_cfg.out_count;
            end
            if (sel_side_en) begin
                side_d = sel_side_val;
            end
        end
    end

    // Response next state: capture the pins at the end of the Pins cycle
    // for reads and writes alike, and strobe the owning requester.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pend_valid_q) begin
            rsp_valid_d[pend_idx_q] = 1'b1;
            rsp_data_d              = pinRead;
        end
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q         <= '0;
            cfg_q        <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            side_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            cfg_q        <= cfg_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            side_q       <= side_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign cfg_inBase   = cfg_q.in_base;
    assign cfg_inCount  = cfg_q.in_count;
    assign cfg_outBase  = cfg_q.out_base;
    assign cfg_outCount = cfg_q.out_count;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
    assign sideSet      = side_q;
    assign rspValid     = rsp_valid_q;
    assign rspData      = rsp_data_q;

endmodule

// File: tb/tb_pin_arbiter.sv
// Directed bench for pin_arbiter: reset values, single write, read after
// write, reset with a transaction in flight, round-robin order, masking by
// smEnable, side-set hold and completion after disable.
module tb_pin_arbiter;

    localparam int N = 4;

    logic            clock;
    logic            reset;
    logic [N-1:0]    smEnable;
    logic [N-1:0]    reqValid;
    logic [N-1:0]    reqWrite;
    logic [32*N-1:0] reqData;
    logic [36*N-1:0] reqCfg;
    logic [N-1:0]    reqSideEn;
    logic [N-1:0]    reqSideVal;
    logic [N-1:0]    reqAck;
    logic [N-1:0]    rspValid;
    logic [31:0]     rspData;
    logic [8:0]      cfg_inBase;
    logic [8:0]      cfg_inCount;
    logic [8:0]      cfg_outBase;
    logic [8:0]      cfg_outCount;
    logic [31:0]     write_data;
    logic            write_enable;
    logic            sideSet;
    logic [31:0]     pinRead;

    int n_cmp;
    int n_err;

    pin_arbiter #(.NUM_SM(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .smEnable     (smEnable),
        .reqValid     (reqValid),
        .reqWrite     (reqWrite),
        .reqData      (reqData),
        .reqCfg       (reqCfg),
        .reqSideEn    (reqSideEn),
        .reqSideVal   (reqSideVal),
        .reqAck       (reqAck),
        .rspValid     (rspValid),
        .rspData      (rspData),
        .cfg_inBase   (cfg_inBase),
        .cfg_inCount  (cfg_inCount),
        .cfg_outBase  (cfg_outBase),
        .cfg_outCount (cfg_outCount),
        .write_data   (write_data),
        .write_enable (write_enable),
        .sideSet      (sideSet),
        .pinRead      (pinRead)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [35:0] mk_cfg(input logic [8:0] ib, input logic [8:0] ic,
                                            input logic [8:0] ob, input logic [8:0] oc);
        return {ib, ic, ob, oc};
    endfunction

    task automatic set_payload(input int sm, input logic [31:0] data, input logic [35:0] cfg);
        reqData[32*sm +: 32] = data;
        reqCfg[36*sm +: 36]  = cfg;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rspValid"}, 36'(rspValid), 36'h0);
        check({tag, " rspData"}, 36'(rspData), 36'h0);
        check({tag, " write_enable"}, 36'(write_enable), 36'h0);
        check({tag, " write_data"}, 36'(write_data), 36'h0);
        check({tag, " sideSet"}, 36'(sideSet), 36'h0);
        check({tag, " cfg_inBase"}, 36'(cfg_inBase), 36'h0);
        check({tag, " cfg_inCount"}, 36'(cfg_inCount), 36'h0);
        check({tag, " cfg_outBase"}, 36'(cfg_outBase), 36'h0);
        check({tag, " cfg_outCount"}, 36'(cfg_outCount), 36'h0);
    endtask

    logic [N-1:0] rr_exp [8];
    logic [N-1:0] mask_exp [4];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        smEnable   = 4'hF;
        reqValid   = 4'hF;
        reqWrite   = 4'h0;
        reqData    = '0;
        reqCfg     = '0;
        reqSideEn  = 4'h0;
        reqSideVal = 4'h0;
        pinRead    = 32'hCAFE_0001;

        // Reset with every requester valid: nothing acked, all outputs zero.
        tick();
        tick();
        check("reset reqAck", 36'(reqAck), 36'h0);
        check_all_zero("reset");

        // Single write from SM2, out window base 4 count 8.
        reset    = 1'b0;
        reqValid = 4'b0100;
        reqWrite = 4'b0100;
        set_payload(2, 32'h0000_00A5, mk_cfg(9'd0, 9'd0, 9'd4, 9'd8));
        #1;
        check("wr reqAck", 36'(reqAck), 36'h4);
        tick();
        reqValid = 4'b0000;
        reqWrite = 4'b0000;
        check("wr N+1 write_enable", 36'(write_enable), 36'h1);
        check("wr N+1 write_data", 36'(write_data), 36'hA5);
        check("wr N+1 cfg_outBase", 36'(cfg_outBase), 36'h4);
        check("wr N+1 cfg_outCount", 36'(cfg_outCount), 36'h8);
        check("wr N+1 rspValid", 36'(rspValid), 36'h0);
        tick();
        check("wr N+2 write_enable", 36'(write_enable), 36'h0);
        check("wr N+2 rspValid", 36'(rspValid), 36'h4);
        check("wr N+2 rspData", 36'(rspData), 36'hCAFE_0001);

        // Read after write on SM1; pointer sits at 3 so search wraps to 1.
        reqValid = 4'b0010;
        reqWrite = 4'b0010;
        set_payload(1, 32'h1357_9BDF, mk_cfg(9'h1FF, 9'd5, 9'd0, 9'd8));
        #1;
        check("raw wr reqAck", 36'(reqAck), 36'h2);
        tick();
        reqWrite = 4'b0000;
        set_payload(1, 32'hFFFF_FFFF, mk_cfg(9'd0, 9'd8, 9'd7, 9'd1));
        #1;
        check("raw rd reqAck", 36'(reqAck), 36'h2);
        check("raw wr write_enable", 36'(write_enable), 36'h1);
        check("raw wr write_data", 36'(write_data), 36'h1357_9BDF);
        check("raw wr cfg_inBase", 36'(cfg_inBase), 36'h1FF);
        check("raw wr cfg_inCount", 36'(cfg_inCount), 36'h5);
        check("raw wr cfg_outBase", 36'(cfg_outBase), 36'h0);
        check("raw wr cfg_outCount", 36'(cfg_outCount), 36'h8);
        tick();
        reqValid = 4'b0000;
        pinRead  = 32'h5A5A_1234;
        check("raw rd write_enable", 36'(write_enable), 36'h0);
        check("raw rd write_data held", 36'(write_data), 36'h1357_9BDF);
        check("raw rd cfg_inBase", 36'(cfg_inBase), 36'h0);
        check("raw rd cfg_inCount", 36'(cfg_inCount), 36'h8);
        check("raw rd cfg_outBase held", 36'(cfg_outBase), 36'h0);
        check("raw rd cfg_outCount held", 36'(cfg_outCount), 36'h8);
        check("raw wr rspValid", 36'(rspValid), 36'h2);
        check("raw wr rspData", 36'(rspData), 36'hCAFE_0001);
        tick();
        check("raw rd rspValid", 36'(rspValid), 36'h2);
        check("raw rd rspData", 36'(rspData), 36'h5A5A_1234);
        tick();
        check("idle rspValid", 36'(rspValid), 36'h0);
        check("idle rspData held", 36'(rspData), 36'h5A5A_1234);
        check("idle cfg_outCount held", 36'(cfg_outCount), 36'h8);

        // Reset one cycle after a grant to SM3 (pointer at 2).
        reqValid = 4'b1000;
        #1;
        check("rst grant reqAck", 36'(reqAck), 36'h8);
        tick();
        reset    = 1'b1;
        reqValid = 4'hF;
        #1;
        check("rst held reqAck", 36'(reqAck), 36'h0);
        tick();
        check_all_zero("rst drop");
        tick();
        check("rst drop later rspValid", 36'(rspValid), 36'h0);

        // All four valid from reset: 0,1,2,3,0,... one per cycle.
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr ack %0d", k), 36'(reqAck), 36'(rr_exp[k]));
            if (k >= 2) begin
                check($sformatf("rr rsp %0d", k), 36'(rspValid), 36'(rr_exp[k-2]));
            end else begin
                check($sformatf("rr rsp %0d", k), 36'(rspValid), 36'h0);
            end
            tick();
        end

        // SM2 masked: never acked, even when it is the only one valid.
        smEnable = 4'b1011;
        mask_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("mask ack %0d", k), 36'(reqAck), 36'(mask_exp[k]));
            tick();
        end
        reqValid = 4'b0100;
        #1;
        check("mask only SM2 reqAck", 36'(reqAck), 36'h0);
        tick();
        reqValid = 4'b0000;
        tick();
        tick();

        // Side-set from SM1, then SM0 without side-set; SM1 disabled while
        // its transaction is in flight must still complete.
        check("side before", 36'(sideSet), 36'h0);
        smEnable   = 4'hF;
        reqValid   = 4'b0010;
        reqSideEn  = 4'b0010;
        reqSideVal = 4'b0010;
        #1;
        check("side SM1 reqAck", 36'(reqAck), 36'h2);
        tick();
        reqValid   = 4'b0001;
        reqSideEn  = 4'b0000;
        reqSideVal = 4'b0000;
        smEnable   = 4'b1101;
        #1;
        check("side SM0 reqAck", 36'(reqAck), 36'h1);
        check("side N+1 sideSet", 36'(sideSet), 36'h1);
        tick();
        reqValid = 4'b0000;
        check("side held sideSet", 36'(sideSet), 36'h1);
        check("side SM1 rspValid", 36'(rspValid), 36'h2);
        tick();
        check("side SM0 rspValid", 36'(rspValid), 36'h1);
        check("side later sideSet", 36'(sideSet), 36'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
